imem_loader: RTL

Boot-time instruction-memory loader and instruction RAM that sits directly upstream of `cpu` on its instruction port. It receives a program as a byte stream over a valid/ready handshake and writes it into a 1024×16 instruction RAM. It holds the CPU in reset until the load completes, then serves `idata` from `iaddr` with one-cycle synchronous read latency. A `load_req` pulse re-enters loading at any time after a run or an error.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_ram.sv | 35 +++
 rtl/imem_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The S_CHK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam int IMEM_DEPTH = 1024;
  localparam int IMEM_AW    = 10;

  // Harmless fill word for benches that want a defined RAM image.
  localparam logic [15:0] OP_NOP = 16'h0800;

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_DAT_LO,
    S_DAT_HI,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_RUN,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 16 instruction RAM: one write port and one registered read port.
// Storage is never reset; only the read register clears on reset.
module imem_ram
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read sees the pre-write contents when raddr == waddr on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a little-endian byte stream, fills imem_ram, and holds
// the CPU in reset until loaded. Optional trailing XOR check: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic               load_req,
  input  logic [IMEM_AW-1:0] iaddr,
  output logic [15:0]        idata,
  output logic               cpu_reset,
  output logic               done,
  output logic               err,
  output loader_state_t      state
);

  // rx handshake: a byte moves on a rising edge where rx_valid && rx_ready;
  // rx_ready depends only on state (and reset), never on rx_valid.

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t LOAD_END = S_CHK;
`else
  localparam loader_state_t LOAD_END = S_RUN;
`endif

  loader_state_t      state_next;
  logic [7:0]         acc;
  logic [15:0]        count;
  logic [IMEM_AW:0]   wptr;
  logic [15:0]        word;
  logic               loading;
  logic               accept;
  logic               we;
  logic               last_word;
  logic               reload;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         chk;
`endif

  assign loading   = (state != S_RUN) && (state != S_ERR);
  assign rx_ready  = loading && !reset;
  assign accept    = rx_valid && rx_ready;
  assign word      = {rx_data, acc};
  assign we        = accept && (state == S_DAT_HI);
  assign last_word = (16'(wptr) + 16'd1) == count;
  assign reload    = !loading && load_req;

  assign cpu_reset = (state != S_RUN);
  assign done      = (state == S_RUN);
  assign err       = (state == S_ERR);

  always_comb begin
    state_next = state;
    case (state)
      S_CNT_LO: if (accept) state_next = S_CNT_HI;
      S_CNT_HI: begin
        if (accept) begin
          if (word > 16'(IMEM_DEPTH)) begin
            state_next = S_ERR;
          end else if (word == '0) begin
            state_next = LOAD_END;
          end else begin
            state_next = S_DAT_LO;
          end
        end
      end
      S_DAT_LO: if (accept) state_next = S_DAT_HI;
      S_DAT_HI: begin
        if (accept) begin
          state_next = last_word ? LOAD_END : S_DAT_LO;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_next = ((chk ^ rx_data) == 8'h00) ? S_RUN : S_ERR;
        end
      end
`endif
      S_RUN, S_ERR: if (load_req) state_next = S_CNT_LO;
      default: state_next = S_CNT_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_CNT_LO;
      acc   <= '0;
      count <= '0;
      wptr  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk   <= '0;
`endif
    end else begin
      state <= state_next;
      // Low bytes of both the count and each data word park in acc.
      if (accept && (state == S_CNT_LO || state == S_DAT_LO)) begin
        acc <= rx_data;
      end
      if (accept && state == S_CNT_HI) begin
        count <= word;
      end
      if (we) begin
        wptr <= wptr + 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (accept) begin
        chk <= chk ^ rx_data;
      end
`endif
      if (reload) begin
        wptr <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk  <= '0;
`endif
      end
    end
  end

  imem_ram #(
    .DEPTH (IMEM_DEPTH),
    .AW    (IMEM_AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (wptr[IMEM_AW-1:0]),
    .wdata (word),
    .raddr (iaddr),
    .rdata (idata)
  );

endmodule
